// File: rtl/sine_table_loader.sv
// Loads the 256 x 32-bit DDS sine table from a byte stream into split 16-bit RAMs,
// then reads the whole table back and compares checksums before flagging done/err.
module sine_table_loader #(
  parameter int ADDR_W = 8,
  parameter int CSUM_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din_h,
  output logic [15:0]       mem_din_l,
  input  logic [15:0]       mem_dout_h,
  input  logic [15:0]       mem_dout_l,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, WRITE, VERIFY, VTAIL, DONE_S
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       word;
  logic [CSUM_W-1:0] wr_csum, rd_csum, rd_csum_nx;
  logic              rd_pend;
  logic              done_q, err_q;

  assign mem_addr   = addr_cnt;
  assign mem_din_h  = word[31:16];
  assign mem_din_l  = word[15:0];
  assign done       = done_q;
  assign err        = err_q;
  assign rd_csum_nx = rd_csum + CSUM_W'(mem_dout_h) + CSUM_W'(mem_dout_l);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = COLLECT;
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && byte_cnt == 2'd3) state_nx = WRITE;
      end
      WRITE: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        busy     = 1'b1;
        state_nx = (addr_cnt == LAST) ? VERIFY : COLLECT;
      end
      VERIFY: begin
        mem_cs = 1'b1;
        busy   = 1'b1;
        if (addr_cnt == LAST) state_nx = VTAIL;
      end
      VTAIL: begin
        busy     = 1'b1;
        state_nx = DONE_S;
      end
      DONE_S:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read data lags its address by one cycle; rd_pend marks a sample due.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt <= '0;
      byte_cnt <= '0;
      word     <= '0;
      wr_csum  <= '0;
      rd_csum  <= '0;
      rd_pend  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_pend <= (state == VERIFY);
      unique case (state)
        IDLE: if (start) begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          addr_cnt <= '0;
          byte_cnt <= '0;
          wr_csum  <= '0;
          rd_csum  <= '0;
        end
        COLLECT: if (in_valid) begin
          word     <= {word[23:0], in_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        WRITE: begin
          wr_csum  <= wr_csum + CSUM_W'(word[31:16])
                    + CSUM_W'(word[15:0]);
          addr_cnt <= addr_cnt + 1'b1;
        end
        VERIFY: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (rd_pend) rd_csum <= rd_csum_nx;
        end
        VTAIL: begin
          rd_csum <= rd_csum_nx;
          done_q  <= 1'b1;
          err_q   <= (rd_csum_nx != wr_csum);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_table_loader.sv
// Directed bench for sine_table_loader: table of full loads against a RAM model,
// plus hand sequences for reset mid-load and start pulses that must be ignored.
module tb_sine_table_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_cs, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din_h, mem_din_l;
  logic [15:0] mem_dout_h, mem_dout_l;

  always #5 clk = ~clk;

  sine_table_loader #(.ADDR_W(8), .CSUM_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din_h(mem_din_h), .mem_din_l(mem_din_l),
    .mem_dout_h(mem_dout_h), .mem_dout_l(mem_dout_l),
    .busy(busy), .done(done), .err(err)
  );

  logic [15:0] ram_h [DEPTH];
  logic [15:0] ram_l [DEPTH];
  bit          fault_en = 1'b0;
  int          cyc = 0;
  int          wr_n = 0;
  logic [7:0]  log_a [512];
  logic [31:0] log_w [512];
  int          log_c [512];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_cs && mem_we) begin
      ram_h[mem_addr] <= mem_din_h;
      ram_l[mem_addr] <= mem_din_l;
      if (wr_n < 512) begin
        log_a[wr_n] = mem_addr;
        log_w[wr_n] = {mem_din_h, mem_din_l};
        log_c[wr_n] = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (mem_cs && !mem_we) begin
      mem_dout_h <= ram_h[mem_addr];
      mem_dout_l <= ram_l[mem_addr]
                  ^ {15'd0, fault_en && mem_addr == 8'd17};
    end
  end

  typedef struct {
    int pat;
    bit gaps;
    bit fault;
    bit spur;
    bit exp_err;
    int exp_cyc;
  } vec_t;

  vec_t vt [5];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [31:0] wd(input int pat, input int i);
    logic [7:0] b;
    b = i[7:0];
    if (pat == 0) return {b, b, b, b};
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, " ctl"},
          {26'd0, in_ready, mem_cs, mem_we, busy, done, err}, 32'd0);
    check({nm, " bus"}, {8'd0, mem_addr, mem_din_h}, 32'd0);
    check({nm, " dinl"}, {16'd0, mem_din_l}, 32'd0);
  endtask

  task automatic run_load(input vec_t v, input int idx);
    int bi, c0, viol, bad, spur_k;
    bit acc;
    logic [31:0] w;
    string tag;
    tag = $sformatf("v%0d", idx);
    wr_n = 0;
    fault_en = v.fault;
    bi = 0;
    viol = 0;
    spur_k = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    c0 = cyc;
    check({tag, " clr"}, {29'd0, done, err, busy}, 32'b001);
    for (int n = 0; n < 20000; n++) begin
      if (done) break;
      w = wd(v.pat, bi / 4);
      in_valid = (bi < 1024) && (!v.gaps || $urandom_range(0, 1) == 1);
      in_data = w[31 - 8 * (bi % 4) -: 8];
      start = v.spur && (n == 2 || (mem_cs && !mem_we && spur_k == 0));
      if (mem_cs && !mem_we) spur_k = 1;
      if (in_ready && (!busy || mem_cs)) viol++;
      acc = in_valid && in_ready;
      tick;
      if (acc) bi++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " err"}, {31'd0, err}, {31'd0, v.exp_err});
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    if (v.exp_cyc != 0)
      check({tag, " cycles"}, cyc - c0 + 1, v.exp_cyc);
    start = v.spur;
    tick;
    start = 1'b0;
    check({tag, " hold"}, {29'd0, done, err, busy},
          {29'd0, 1'b1, v.exp_err, 1'b0});
    tick;
    tick;
    check({tag, " hold2"}, {29'd0, done, err, busy},
          {29'd0, 1'b1, v.exp_err, 1'b0});
    check({tag, " writes"}, wr_n, DEPTH);
    bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (log_a[k] != k[7:0] || log_w[k] != wd(v.pat, k)) bad++;
    check({tag, " wrseq"}, bad, 0);
    check({tag, " rdy"}, viol, 0);
    if (v.exp_cyc != 0) check({tag, " wr0cyc"}, log_c[0] - c0, 5);
    if (v.pat == 0) begin
      check({tag, " din0"}, {16'd0, log_w[0][31:16]}, 32'h0000);
      check({tag, " din255"}, {16'd0, log_w[255][31:16]}, 32'hFFFF);
    end
  endtask

  initial begin
    vt[0] = '{pat: 0, gaps: 0, fault: 0, spur: 0, exp_err: 0, exp_cyc: 1538};
    vt[1] = '{pat: 0, gaps: 0, fault: 1, spur: 0, exp_err: 1, exp_cyc: 1538};
    vt[2] = '{pat: 1, gaps: 0, fault: 0, spur: 0, exp_err: 0, exp_cyc: 1538};
    vt[3] = '{pat: 0, gaps: 1, fault: 0, spur: 0, exp_err: 0, exp_cyc: 0};
    vt[4] = '{pat: 0, gaps: 0, fault: 0, spur: 1, exp_err: 0, exp_cyc: 1538};

    tick;
    tick;
    check_zero("por");
    reset = 1'b0;
    tick;

    start = 1'b1;
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hDE;
    tick;
    in_data = 8'hAD;
    tick;
    in_valid = 1'b0;
    check({"mid busy"}, {30'd0, busy, in_ready}, 32'b11);
    reset = 1'b1;
    #2;
    check_zero("midrst");
    tick;
    reset = 1'b0;
    tick;

    for (int i = 0; i < 5; i++) run_load(vt[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
